// File: rtl/data_bus_xfer_ctrl_if.sv
// rtl/data_bus_xfer_ctrl_if.sv - source/destination signal bundle for data_bus_xfer_ctrl
interface data_bus_xfer_ctrl_if;
    logic       req1;
    logic       req2;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       dest1;
    logic       dest2;
    logic       ready1;
    logic       ready2;
    logic [7:0] dataOut1;
    logic [7:0] dataOut2;
    logic       valid1;
    logic       valid2;
    logic       ack1;
    logic       ack2;
    logic       err;
    logic       grant;
    logic       busy;

    modport master (
        input  req1, req2, data1, data2, dest1, dest2, ready1, ready2,
        output dataOut1, dataOut2, valid1, valid2, ack1, ack2, err, grant, busy
    );

    modport slave (
        output req1, req2, data1, data2, dest1, dest2, ready1, ready2,
        input  dataOut1, dataOut2, valid1, valid2, ack1, ack2, err, grant, busy
    );
endinterface

// File: rtl/data_bus_xfer_ctrl.sv
// rtl/data_bus_xfer_ctrl.sv - two-source/two-destination byte transfer controller
// Optional DATA_BUS_RR_EN: round-robin tie arbitration (default: source 1 wins ties).
module data_bus_xfer_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 reset,
    data_bus_xfer_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DELIVER, DONE} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [7:0] data_q,  data_d;
    logic       dest_q,  dest_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] out1_q,  out1_d;
    logic [7:0] out2_q,  out2_d;
    logic       v1_q,    v1_d;
    logic       v2_q,    v2_d;
    logic       ack1_q,  ack1_d;
    logic       ack2_q,  ack2_d;
    logic       err_q,   err_d;
    logic       busy_q,  busy_d;
    logic       tie_winner;
    logic       sel_ready;

`ifdef DATA_BUS_RR_EN
    assign tie_winner = ~owner_q;
`else
    assign tie_winner = 1'b0;
`endif

    // Only the latched destination's ready counts; the other one is ignored.
    assign sel_ready = dest_q ? bus.ready2 : bus.ready1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        data_d  = data_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        out1_d  = 8'h00;
        out2_d  = 8'h00;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        ack1_d  = 1'b0;
        ack2_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req1 || bus.req2) begin
                    owner_d = (bus.req1 && bus.req2) ? tie_winner : bus.req2;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = owner_q ? bus.data2 : bus.data1;
                dest_d  = owner_q ? bus.dest2 : bus.dest1;
                cnt_d   = 8'd0;
                v1_d    = ~dest_d;
                v2_d    = dest_d;
                out1_d  = dest_d ? 8'h00 : data_d;
                out2_d  = dest_d ? data_d : 8'h00;
                state_d = DELIVER;
            end
            DELIVER: begin
                if (sel_ready) begin
                    ack1_d  = ~owner_q;
                    ack2_d  = owner_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO) begin
                        ack1_d  = ~owner_q;
                        ack2_d  = owner_q;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        v1_d   = ~dest_q;
                        v2_d   = dest_q;
                        out1_d = dest_q ? 8'h00 : data_q;
                        out2_d = dest_q ? data_q : 8'h00;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            data_q  <= 8'h00;
            dest_q  <= 1'b0;
            cnt_q   <= 8'd0;
            out1_q  <= 8'h00;
            out2_q  <= 8'h00;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            ack1_q  <= 1'b0;
            ack2_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            ack1_q  <= ack1_d;
            ack2_q  <= ack2_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.dataOut1 = out1_q;
    assign bus.dataOut2 = out2_q;
    assign bus.valid1   = v1_q;
    assign bus.valid2   = v2_q;
    assign bus.ack1     = ack1_q;
    assign bus.ack2     = ack2_q;
    assign bus.err      = err_q;
    assign bus.grant    = owner_q;
    assign bus.busy     = busy_q;
endmodule

// File: doc/data_bus_xfer_ctrl.md
# data_bus_xfer_ctrl

Sequential transfer controller for the shared 8-bit two-source / two-destination data bus. It arbitrates between two requesting sources and latches the winner's byte and destination. It delivers the byte to the chosen destination through a valid/ready handshake and returns a completion pulse to the source. It is the initiator-side counterpart of the combinational mux/tri-state bus, replacing a hand-driven `select` with a protocol-driven one.

## Interface
- `TIMEOUT`, default 15: maximum DELIVER cycles waiting for destination `ready` before abort. Legal range 1..255.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `req1`, `req2`  in  1  source request; held until matching ack
- `data1`, `data2`  in  8  source byte, stable while req high
- `dest1`, `dest2`  in  1  target of request: 0 → destination 1, 1 → destination 2
- `ready1`, `ready2`  in  1  destination accepts byte this cycle
- `dataOut1`, `dataOut2`  out  8  registered byte to destination; 8'h00 when not valid
- `valid1`, `valid2`  out  1  byte on `dataOutN` is offered
- `ack1`, `ack2`  out  1  one-cycle completion pulse to source
- `err`  out  1  one-cycle pulse, coincident with ack, when transfer timed out
- `grant`  out  1  current/last bus owner: 0 = source 1, 1 = source 2
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LOAD, DELIVER, DONE. Reset → IDLE.
- IDLE: sample `req1`/`req2`. If none, stay. If one, grant it. If both, arbitrate as described under Configuration. Go to LOAD.
- LOAD (1 cycle): latch granted source's data byte and dest bit into internal registers; clear timeout counter; `grant` updated. Go to DELIVER.
- DELIVER:
  - Drive the latched byte on the selected `dataOutN` with `validN`=1; the other output is 8'h00 with valid 0.
  - If the selected `readyN`=1, the transfer completes; go to DONE with err flag 0.
  - Else increment the 8-bit counter. If the counter reaches `TIMEOUT`, go to DONE with err flag 1.
  - The `ready` of the non-selected destination is ignored.
- DONE (1 cycle): `ackN`=1 for the granted source; `err` = latched flag; valid outputs 0. Go to IDLE.
- Sources must drop req at the edge ending DONE. A req still high in IDLE is treated as a new request.
- Data and dest bits are latched in LOAD only. Input changes after LOAD do not affect the transfer.
- Timeout produces no delivery: the destination never saw `ready` together with `valid`.

## Timing
- Reset values: `dataOut1`/`dataOut2`=8'h00, `valid*`=0, `ack*`=0, `err`=0, `busy`=0, `grant`=1 (last-owner register = source 2), counter=0.
- Cycle N IDLE with req → N+1 LOAD → N+2 DELIVER, first valid → DONE on the cycle after the `ready` sample → IDLE.
- Minimum 4 cycles per transfer. Back-to-back requests: a new LOAD no earlier than 2 cycles after DONE.
- Timeout path: valid is high for exactly `TIMEOUT` cycles, then DONE with err=1.
- `TIMEOUT`=1 gives a single DELIVER cycle.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset asserted in any state: next cycle IDLE with all reset values. The in-flight transfer is discarded and no ack is issued.

## Configuration
- `DATA_BUS_RR_EN` defined:
  - Simultaneous requests are granted round-robin: the source that is not the last owner wins.
  - The last-owner register updates in LOAD.
  - After reset, source 1 wins the first tie.
- Not defined:
  - Fixed priority: source 1 always wins a tie.
  - The last-owner register still drives `grant`.

## Test plan
- Single transfer, normal path:
  - Stimulus: reset, then `req1`=1, `data1`=8'hA5, `dest1`=1, `ready2` tied high.
  - Required: `dataOut2`=8'hA5 with `valid2`=1 for 1 cycle; `ack1` 1 cycle later; `err`=0; `dataOut1`=8'h00 throughout.
- Timeout:
  - Stimulus: `TIMEOUT`=3; `req2`=1, `data2`=8'h3C, `dest2`=0; `ready1`=0.
  - Required: `valid1` high for exactly 3 cycles, then `ack2`=1 with `err`=1.
- Tie arbitration with `DATA_BUS_RR_EN`:
  - Stimulus: both reqs held high for 4 transfers.
  - Required: grants alternate 1,2,1,2.
  - Without the macro, the same stimulus must grant 1,1,1,1.
- Latching:
  - Stimulus: change `data1` from 8'h11 to 8'hFF during DELIVER, with delayed `ready`.
  - Required: the delivered byte stays 8'h11.
- Reset mid-DELIVER:
  - Stimulus: assert `reset` for 1 cycle while `valid1`=1.
  - Required: next cycle all outputs at reset values, `busy`=0, and no `ack` pulse follows.
